// File: rtl/s_axi_reg_pkg.sv
// ---------------------------------------------------------------------------
// s_axi_reg_pkg
// Shared definitions for the AXI slave register bank:
//   - AXI response codes (OKAY / SLVERR / DECERR)
//   - write and read channel FSM state enums
//   - address decode function returning {index, resp}
// No ports (package).
// ---------------------------------------------------------------------------
package s_axi_reg_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_ADDR = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_ADDR = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // The index is kept at a fixed 32-bit width so the package does not depend
    // on NUM_REGS; callers compare it against their own register numbers.
    typedef struct packed {
        logic [31:0] index;
        logic [1:0]  resp;
    } dec_t;

    // Misalignment takes priority over the range check; index is only
    // meaningful when resp is OKAY and is zero otherwise.
    function automatic dec_t decode(input logic [63:0] byte_addr,
                                    input int unsigned wb,
                                    input int unsigned num_regs);
        dec_t d;
        d.index = '0;
        d.resp  = RESP_OKAY;
        if ((byte_addr % 64'(wb)) != 64'd0) begin
            d.resp = RESP_SLVERR;
        end else if (byte_addr >= (64'(wb) * 64'(num_regs))) begin
            d.resp = RESP_DECERR;
        end else begin
            d.index = 32'(byte_addr / 64'(wb));
        end
        return d;
    endfunction

endpackage

// File: rtl/s_axi_reg_bank_if.sv
// ---------------------------------------------------------------------------
// s_axi_reg_bank_if
// AXI slave bus bundle for s_axi_reg_bank.
//   AW: awid_i, awaddr_i, awvalid_i, awready_o
//   W : wdata_i, wstrb_i, wvalid_i, wready_o
//   B : bid_o, bresp_o, bvalid_o, bready_i
//   AR: arid_i, araddr_i, arvalid_i, arready_o
//   R : rid_o, rdata_o, rresp_o, rvalid_o, rready_i
//   w_state_dbg / r_state_dbg: current write/read FSM state (observation only)
// Modports: slave (the register bank), master (the bus driver).
//
// Handshake rule on every channel: a transfer happens on a rising clk edge
// where both valid and ready are 1. A source holds valid and payload stable
// until that edge; no valid output depends combinationally on its ready.
// ---------------------------------------------------------------------------
interface s_axi_reg_bank_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import s_axi_reg_pkg::*;

    logic [ID_W-1:0]     awid_i;
    logic [ADDR_W-1:0]   awaddr_i;
    logic                awvalid_i;
    logic                awready_o;

    logic [DATA_W-1:0]   wdata_i;
    logic [DATA_W/8-1:0] wstrb_i;
    logic                wvalid_i;
    logic                wready_o;

    logic [ID_W-1:0]     bid_o;
    logic [1:0]          bresp_o;
    logic                bvalid_o;
    logic                bready_i;

    logic [ID_W-1:0]     arid_i;
    logic [ADDR_W-1:0]   araddr_i;
    logic                arvalid_i;
    logic                arready_o;

    logic [ID_W-1:0]     rid_o;
    logic [DATA_W-1:0]   rdata_o;
    logic [1:0]          rresp_o;
    logic                rvalid_o;
    logic                rready_i;

    w_state_t            w_state_dbg;
    r_state_t            r_state_dbg;

    modport slave (
        input  awid_i, awaddr_i, awvalid_i,
        output awready_o,
        input  wdata_i, wstrb_i, wvalid_i,
        output wready_o,
        output bid_o, bresp_o, bvalid_o,
        input  bready_i,
        input  arid_i, araddr_i, arvalid_i,
        output arready_o,
        output rid_o, rdata_o, rresp_o, rvalid_o,
        input  rready_i,
        output w_state_dbg, r_state_dbg
    );

    modport master (
        output awid_i, awaddr_i, awvalid_i,
        input  awready_o,
        output wdata_i, wstrb_i, wvalid_i,
        input  wready_o,
        input  bid_o, bresp_o, bvalid_o,
        output bready_i,
        output arid_i, araddr_i, arvalid_i,
        input  arready_o,
        input  rid_o, rdata_o, rresp_o, rvalid_o,
        output rready_i,
        input  w_state_dbg, r_state_dbg
    );

endinterface

// File: rtl/s_axi_reg_rd_ch.sv
// ---------------------------------------------------------------------------
// s_axi_reg_rd_ch
// Read channel of the register bank: AR/R FSM plus the registered R payload.
// Ports:
//   clk, areset   clock, asynchronous active-low reset
//   i_arid, i_araddr, i_arvalid, o_arready    read address channel
//   o_rid, o_rdata, o_rresp, o_rvalid, i_rready  read data channel
//   i_regs        flat register contents, register k at [k*DATA_W +: DATA_W]
//   o_state       current FSM state (observation)
// ---------------------------------------------------------------------------
module s_axi_reg_rd_ch
    import s_axi_reg_pkg::*;
#(
    parameter int ID_W     = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8
) (
    input  logic                       clk,
    input  logic                       areset,
    input  logic [ID_W-1:0]            i_arid,
    input  logic [ADDR_W-1:0]          i_araddr,
    input  logic                       i_arvalid,
    output logic                       o_arready,
    output logic [ID_W-1:0]            o_rid,
    output logic [DATA_W-1:0]          o_rdata,
    output logic [1:0]                 o_rresp,
    output logic                       o_rvalid,
    input  logic                       i_rready,
    input  logic [NUM_REGS*DATA_W-1:0] i_regs,
    output r_state_t                   o_state
);

    localparam int WB = DATA_W / 8;

    r_state_t          r_state;
    r_state_t          w_next;
    logic              w_arready;
    logic              w_rvalid;
    logic              w_ar_hs;
    dec_t              w_ar_dec;
    logic [DATA_W-1:0] w_rd_val;

    logic [ID_W-1:0]   r_rid;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_state <= R_ADDR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_arready = 1'b0;
        w_rvalid  = 1'b0;
        case (r_state)
            R_ADDR: begin
                w_arready = 1'b1;
                if (i_arvalid) w_next = R_DATA;
            end
            R_DATA: begin
                w_rvalid = 1'b1;
                if (i_rready) w_next = R_ADDR;
            end
            default: w_next = R_ADDR;
        endcase
    end

    assign w_ar_hs  = w_arready & i_arvalid;
    assign w_ar_dec = decode(64'(i_araddr), WB, NUM_REGS);

    // Register value as it stands before the AR edge; a write landing on the
    // same edge is therefore not visible to this read.
    always_comb begin
        w_rd_val = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_ar_dec.resp == RESP_OKAY && w_ar_dec.index == 32'(k)) begin
                w_rd_val = i_regs[k*DATA_W +: DATA_W];
            end
        end
    end

    // Payload only moves on the AR handshake, so it stays frozen while R
    // is stalled by i_rready.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_rid   <= '0;
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rid   <= i_arid;
            r_rdata <= w_rd_val;
            r_rresp <= w_ar_dec.resp;
        end
    end

    assign o_arready = w_arready;
    assign o_rvalid  = w_rvalid;
    assign o_rid     = r_rid;
    assign o_rdata   = r_rdata;
    assign o_rresp   = r_rresp;
    assign o_state   = r_state;

endmodule

// File: rtl/s_axi_reg_bank.sv
// ---------------------------------------------------------------------------
// s_axi_reg_bank
// AXI slave register bank: NUM_REGS registers of DATA_W bits with
// independent write (AW/W/B) and read (AR/R) channels, byte strobes,
// transaction IDs and SLVERR/DECERR responses.
// Ports:
//   clk      clock, all logic on posedge
//   areset   asynchronous active-low reset
//   s_axi    s_axi_reg_bank_if.slave bus bundle (AW, W, B, AR, R + FSM state)
//   regs_o   flat register contents, register k at [k*DATA_W +: DATA_W]
// Build option:
//   S_AXI_REG_BANK_CNT_EN  register NUM_REGS-1 becomes a read-only
//                          free-running counter; writes to it get SLVERR.
// The write FSM, register array and counter live here; the read channel is
// in s_axi_reg_rd_ch.
// ---------------------------------------------------------------------------
module s_axi_reg_bank
    import s_axi_reg_pkg::*;
#(
    parameter int ID_W     = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8
) (
    input  logic                       clk,
    input  logic                       areset,
    s_axi_reg_bank_if.slave            s_axi,
    output logic [NUM_REGS*DATA_W-1:0] regs_o
);

    localparam int WB = DATA_W / 8;

`ifdef S_AXI_REG_BANK_CNT_EN
    localparam int RW_REGS = NUM_REGS - 1;
`else
    localparam int RW_REGS = NUM_REGS;
`endif

    // -----------------------------------------------------------------------
    // Write channel FSM
    // -----------------------------------------------------------------------
    w_state_t          r_w_state;
    w_state_t          w_w_next;
    logic              w_awready;
    logic              w_wready;
    logic              w_bvalid;
    logic              w_aw_hs;
    logic              w_w_hs;

    logic [ID_W-1:0]   w_awid;
    logic [ADDR_W-1:0] w_awaddr;
    dec_t              w_aw_dec;

    logic [ID_W-1:0]   r_bid;
    dec_t              r_wdec;

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_w_state <= W_ADDR;
        end else begin
            r_w_state <= w_w_next;
        end
    end

    always_comb begin
        w_w_next  = r_w_state;
        w_awready = 1'b0;
        w_wready  = 1'b0;
        w_bvalid  = 1'b0;
        case (r_w_state)
            W_ADDR: begin
                w_awready = 1'b1;
                if (s_axi.awvalid_i) w_w_next = W_DATA;
            end
            W_DATA: begin
                w_wready = 1'b1;
                if (s_axi.wvalid_i) w_w_next = W_RESP;
            end
            W_RESP: begin
                w_bvalid = 1'b1;
                if (s_axi.bready_i) w_w_next = W_ADDR;
            end
            default: w_w_next = W_ADDR;
        endcase
    end

    assign w_aw_hs  = w_awready & s_axi.awvalid_i;
    assign w_w_hs   = w_wready & s_axi.wvalid_i;
    assign w_awid   = s_axi.awid_i;
    assign w_awaddr = s_axi.awaddr_i;

    // The decode is resolved at AW time, so the W beat only needs to look
    // at the captured result.
    always_comb begin
        w_aw_dec = decode(64'(w_awaddr), WB, NUM_REGS);
`ifdef S_AXI_REG_BANK_CNT_EN
        if (w_aw_dec.resp == RESP_OKAY && w_aw_dec.index == 32'(NUM_REGS - 1)) begin
            w_aw_dec.resp = RESP_SLVERR;
        end
`endif
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_bid  <= '0;
            r_wdec <= '0;
        end else if (w_aw_hs) begin
            r_bid  <= w_awid;
            r_wdec <= w_aw_dec;
        end
    end

    // -----------------------------------------------------------------------
    // Register array (and optional counter in the top slot)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            for (int k = 0; k < RW_REGS; k++) begin
                if (w_w_hs && r_wdec.resp == RESP_OKAY && r_wdec.index == 32'(k)) begin
                    for (int b = 0; b < WB; b++) begin
                        if (s_axi.wstrb_i[b]) begin
                            r_regs[k][b*8 +: 8] <= s_axi.wdata_i[b*8 +: 8];
                        end
                    end
                end
            end
`ifdef S_AXI_REG_BANK_CNT_EN
            // Wraps naturally at 2^DATA_W.
            r_regs[NUM_REGS-1] <= r_regs[NUM_REGS-1] + DATA_W'(1);
`endif
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_o[g*DATA_W +: DATA_W] = r_regs[g];
    end

    // -----------------------------------------------------------------------
    // Read channel
    // -----------------------------------------------------------------------
    s_axi_reg_rd_ch #(
        .ID_W     (ID_W),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_rd_ch (
        .clk       (clk),
        .areset    (areset),
        .i_arid    (s_axi.arid_i),
        .i_araddr  (s_axi.araddr_i),
        .i_arvalid (s_axi.arvalid_i),
        .o_arready (s_axi.arready_o),
        .o_rid     (s_axi.rid_o),
        .o_rdata   (s_axi.rdata_o),
        .o_rresp   (s_axi.rresp_o),
        .o_rvalid  (s_axi.rvalid_o),
        .i_rready  (s_axi.rready_i),
        .i_regs    (regs_o),
        .o_state   (s_axi.r_state_dbg)
    );

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign s_axi.awready_o   = w_awready;
    assign s_axi.wready_o    = w_wready;
    assign s_axi.bvalid_o    = w_bvalid;
    assign s_axi.bid_o       = r_bid;
    assign s_axi.bresp_o     = r_wdec.resp;
    assign s_axi.w_state_dbg = r_w_state;

endmodule

// File: tb/tb_s_axi_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_s_axi_reg_bank
// Directed plus randomized bench for s_axi_reg_bank (ID_W=4, ADDR_W=32,
// DATA_W=32, NUM_REGS=8). Inputs change on the falling edge, outputs are
// sampled on the falling edge. The reference model is a plain array of
// register words updated from the address/strobe rules.
// ---------------------------------------------------------------------------
module tb_s_axi_reg_bank;

    localparam int BUDGET = 50;

    logic         clk = 1'b0;
    logic         areset = 1'b0;
    logic [255:0] regs_o;

    int checks = 0;
    int failures = 0;

    logic [31:0] model_regs [8];
    logic [31:0] exp_q [$];
    time         ar_time;

    s_axi_reg_bank_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) bus ();

    s_axi_reg_bank #(
        .ID_W     (4),
        .ADDR_W   (32),
        .DATA_W   (32),
        .NUM_REGS (8)
    ) dut (
        .clk    (clk),
        .areset (areset),
        .s_axi  (bus),
        .regs_o (regs_o)
    );

    // -------------------------------------------------------------------
    // Clock
    // -------------------------------------------------------------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------
    // Checking and model
    // -------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] spec_resp(input logic [31:0] a);
        if ((a % 32'd4) != 32'd0) return 2'b10;
        if (a >= 32'd32) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [1:0] exp_wresp(input logic [31:0] a);
        logic [1:0] r;
        r = spec_resp(a);
`ifdef S_AXI_REG_BANK_CNT_EN
        if (r == 2'b00 && a == 32'd28) r = 2'b10;
`endif
        return r;
    endfunction

    function automatic bit is_counter(input logic [31:0] a);
`ifdef S_AXI_REG_BANK_CNT_EN
        return (a == 32'd28);
`else
        return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        idx = int'(a / 32'd4);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) model_regs[idx][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    task automatic check_regs(input string tag);
        for (int k = 0; k < 8; k++) begin
            if (!is_counter(32'(k * 4))) begin
                check($sformatf("%s_reg%0d", tag, k), 64'(regs_o[k*32 +: 32]), 64'(model_regs[k]));
            end
        end
    endtask

    // -------------------------------------------------------------------
    // Channel drivers
    // -------------------------------------------------------------------
    task automatic aw_phase(input logic [3:0] id, input logic [31:0] addr);
        int n;
        n = 0;
        @(negedge clk);
        check("wready_before_aw", 64'(bus.wready_o), 64'd0);
        bus.awid_i    = id;
        bus.awaddr_i  = addr;
        bus.awvalid_i = 1'b1;
        while (!bus.awready_o && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("aw_ready_wait", 64'(n), 64'd0);
        @(posedge clk);
        #1;
        bus.awvalid_i = 1'b0;
    endtask

    task automatic w_phase(input logic [31:0] data, input logic [3:0] strb);
        int n;
        n = 0;
        @(negedge clk);
        bus.wdata_i  = data;
        bus.wstrb_i  = strb;
        bus.wvalid_i = 1'b1;
        while (!bus.wready_o && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("w_ready_wait", 64'(n), 64'd0);
        @(posedge clk);
        #1;
        bus.wvalid_i = 1'b0;
    endtask

    task automatic b_phase(input int hold, output logic [3:0] bid, output logic [1:0] bresp);
        int n;
        n = 0;
        @(negedge clk);
        bus.bready_i = 1'b0;
        while (!bus.bvalid_o && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("b_latency", 64'(n), 64'd0);
        bid   = bus.bid_o;
        bresp = bus.bresp_o;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("b_hold_valid", 64'(bus.bvalid_o), 64'd1);
            check("b_hold_id", 64'(bus.bid_o), 64'(bid));
            check("b_hold_resp", 64'(bus.bresp_o), 64'(bresp));
            check("b_hold_awready", 64'(bus.awready_o), 64'd0);
        end
        bus.bready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.bready_i = 1'b0;
    endtask

    task automatic ar_phase(input logic [3:0] id, input logic [31:0] addr);
        int n;
        n = 0;
        @(negedge clk);
        bus.arid_i    = id;
        bus.araddr_i  = addr;
        bus.arvalid_i = 1'b1;
        while (!bus.arready_o && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("ar_ready_wait", 64'(n), 64'd0);
        @(posedge clk);
        ar_time = $time;
        #1;
        bus.arvalid_i = 1'b0;
    endtask

    task automatic r_phase(input int hold, output logic [3:0] rid, output logic [31:0] rdata,
                           output logic [1:0] rresp);
        int n;
        n = 0;
        @(negedge clk);
        bus.rready_i = 1'b0;
        while (!bus.rvalid_o && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("r_latency", 64'(n), 64'd0);
        rid   = bus.rid_o;
        rdata = bus.rdata_o;
        rresp = bus.rresp_o;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("r_hold_valid", 64'(bus.rvalid_o), 64'd1);
            check("r_hold_data", 64'(bus.rdata_o), 64'(rdata));
        end
        bus.rready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.rready_i = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int hold);
        logic [3:0] bid;
        logic [1:0] bresp;
        logic [1:0] er;
        aw_phase(id, addr);
        w_phase(data, strb);
        b_phase(hold, bid, bresp);
        er = exp_wresp(addr);
        check("bid", 64'(bid), 64'(id));
        check("bresp", 64'(bresp), 64'(er));
        if (er == 2'b00) model_write(addr, data, strb);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int hold,
                           output logic [31:0] data);
        logic [3:0]  rid;
        logic [1:0]  rresp;
        logic [1:0]  er;
        logic [31:0] exp_d;
        er = spec_resp(addr);
        if (!is_counter(addr)) exp_q.push_back((er == 2'b00) ? model_regs[addr / 32'd4] : 32'd0);
        ar_phase(id, addr);
        r_phase(hold, rid, data, rresp);
        check("rid", 64'(rid), 64'(id));
        check("rresp", 64'(rresp), 64'(er));
        if (!is_counter(addr)) begin
            exp_d = exp_q.pop_front();
            check("rdata", 64'(data), 64'(exp_d));
        end
    endtask

    // -------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------
    initial begin
        logic [31:0] rd;
        logic [31:0] rd2;
        logic [3:0]  bid;
        logic [1:0]  bresp;
        logic [31:0] a;
        time         t1;

        bus.awid_i = '0; bus.awaddr_i = '0; bus.awvalid_i = 1'b0;
        bus.wdata_i = '0; bus.wstrb_i = '0; bus.wvalid_i = 1'b0;
        bus.bready_i = 1'b0;
        bus.arid_i = '0; bus.araddr_i = '0; bus.arvalid_i = 1'b0;
        bus.rready_i = 1'b0;
        for (int k = 0; k < 8; k++) model_regs[k] = 32'd0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 64'(bus.awready_o), 64'd1);
        check("rst_arready", 64'(bus.arready_o), 64'd1);
        check("rst_wready", 64'(bus.wready_o), 64'd0);
        check("rst_bvalid", 64'(bus.bvalid_o), 64'd0);
        check("rst_rvalid", 64'(bus.rvalid_o), 64'd0);
        check("rst_bid", 64'(bus.bid_o), 64'd0);
        check("rst_bresp", 64'(bus.bresp_o), 64'd0);
        check("rst_rid", 64'(bus.rid_o), 64'd0);
        check("rst_rdata", 64'(bus.rdata_o), 64'd0);
        check("rst_rresp", 64'(bus.rresp_o), 64'd0);
        for (int k = 0; k < 8; k++) check("rst_regs", 64'(regs_o[k*32 +: 32]), 64'd0);
        areset = 1'b1;

        // Basic full-word write and read-back
        do_write(4'd3, 32'h4, 32'hABCD_EF01, 4'hF, 0);
        do_read(4'd5, 32'h4, 0, rd);
        check_regs("basic");

        // Byte strobes over an all-ones register
        do_write(4'd1, 32'h8, 32'hFFFF_FFFF, 4'hF, 0);
        do_write(4'd2, 32'h8, 32'h1122_3344, 4'h5, 0);
        do_read(4'd6, 32'h8, 1, rd);
        check("strobe_merge", 64'(rd), 64'hFF22_FF44);

        // Error responses leave the registers alone
        do_write(4'd7, 32'h20, 32'hDEAD_BEEF, 4'hF, 0);
        do_write(4'd8, 32'h2, 32'hDEAD_BEEF, 4'hF, 0);
        do_read(4'd9, 32'h20, 0, rd);
        do_read(4'd10, 32'h2, 0, rd);
        check_regs("err");

        // B backpressure for 10 cycles, then next AW one cycle after release
        aw_phase(4'd4, 32'hC);
        w_phase(32'h0BAD_F00D, 4'hF);
        b_phase(10, bid, bresp);
        check("bp_bid", 64'(bid), 64'd4);
        check("bp_bresp", 64'(bresp), 64'd0);
        model_write(32'hC, 32'h0BAD_F00D, 4'hF);
        aw_phase(4'd11, 32'h10);
        check("bp_next_aw_bvalid", 64'(bus.bvalid_o), 64'd0);
        @(negedge clk);
        check("bp_next_wready", 64'(bus.wready_o), 64'd1);
        bus.bready_i = 1'b0;
        w_phase(32'h1357_9BDF, 4'hF);
        b_phase(0, bid, bresp);
        check("bp2_bid", 64'(bid), 64'd11);
        model_write(32'h10, 32'h1357_9BDF, 4'hF);

        // Same-edge write and read on index 2
        do_write(4'd1, 32'h8, 32'h9, 4'hF, 0);
        aw_phase(4'd12, 32'h8);
        @(negedge clk);
        bus.wdata_i = 32'h5; bus.wstrb_i = 4'hF; bus.wvalid_i = 1'b1;
        bus.arid_i = 4'd13; bus.araddr_i = 32'h8; bus.arvalid_i = 1'b1;
        check("coll_wready", 64'(bus.wready_o), 64'd1);
        check("coll_arready", 64'(bus.arready_o), 64'd1);
        @(posedge clk);
        #1;
        bus.wvalid_i = 1'b0; bus.arvalid_i = 1'b0;
        @(negedge clk);
        check("coll_rvalid", 64'(bus.rvalid_o), 64'd1);
        check("coll_rdata_old", 64'(bus.rdata_o), 64'h9);
        check("coll_rid", 64'(bus.rid_o), 64'd13);
        check("coll_bvalid", 64'(bus.bvalid_o), 64'd1);
        check("coll_bid", 64'(bus.bid_o), 64'd12);
        check("coll_reg_new", 64'(regs_o[2*32 +: 32]), 64'h5);
        bus.bready_i = 1'b1; bus.rready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.bready_i = 1'b0; bus.rready_i = 1'b0;
        model_write(32'h8, 32'h5, 4'hF);
        do_read(4'd14, 32'h8, 0, rd);
        check("coll_rdata_new", 64'(rd), 64'h5);

        // Randomized write/read pairs
        for (int it = 0; it < 40; it++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 7)       a = 32'($urandom_range(0, 7)) * 32'd4;
            else if (sel == 7) a = 32'($urandom_range(0, 7)) * 32'd4 + 32'($urandom_range(1, 3));
            else if (sel == 8) a = 32'd32 + 32'($urandom_range(0, 100)) * 32'd4;
            else               a = 32'hFFFF_FFFC;
            do_write(4'($urandom_range(0, 15)), a, $urandom, 4'($urandom_range(0, 15)),
                     int'($urandom_range(0, 2)));
            do_read(4'($urandom_range(0, 15)), a, int'($urandom_range(0, 2)), rd);
        end
        check_regs("rand");

`ifdef S_AXI_REG_BANK_CNT_EN
        // Counter: read twice, difference equals elapsed AR edges
        do_read(4'd1, 32'h1C, 0, rd);
        t1 = ar_time;
        repeat (3) @(posedge clk);
        do_read(4'd2, 32'h1C, 0, rd2);
        check("cnt_delta", 64'(rd2 - rd), 64'((ar_time - t1) / 10));
        do_write(4'd3, 32'h1C, 32'h0, 4'hF, 0);
`else
        t1 = 0;
        rd2 = 32'd0;
`endif

        // Reset while in W_DATA
        aw_phase(4'd5, 32'h14);
        @(negedge clk);
        check("mid_wready", 64'(bus.wready_o), 64'd1);
        bus.wdata_i = 32'hCAFE_CAFE; bus.wstrb_i = 4'hF; bus.wvalid_i = 1'b1;
        areset = 1'b0;
        #1;
        check("mid_rst_wready", 64'(bus.wready_o), 64'd0);
        check("mid_rst_bvalid", 64'(bus.bvalid_o), 64'd0);
        check("mid_rst_rvalid", 64'(bus.rvalid_o), 64'd0);
        check("mid_rst_awready", 64'(bus.awready_o), 64'd1);
        bus.wvalid_i = 1'b0;
        repeat (2) @(negedge clk);
        areset = 1'b1;
        for (int k = 0; k < 8; k++) model_regs[k] = 32'd0;
        repeat (3) @(negedge clk);
        check("post_rst_bvalid", 64'(bus.bvalid_o), 64'd0);
        check("post_rst_wready", 64'(bus.wready_o), 64'd0);
        check_regs("post_rst");
`ifdef S_AXI_REG_BANK_CNT_EN
        do_read(4'd6, 32'h1C, 0, rd);
        check("cnt_near_zero", 64'(rd < 32'd16), 64'd1);
`endif
        do_write(4'd7, 32'h0, 32'h7777_0000, 4'hC, 0);
        do_read(4'd8, 32'h0, 0, rd);
        check_regs("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/s_axi_reg_bank.md
# s_axi_reg_bank

Parametrised AXI slave register bank: NUM_REGS word registers with independent write (AW/W/B) and read (AR/R) channels, byte strobes, transaction IDs and error responses. It succeeds the single-register write-only slave and is the control/status front end of the counter subsystem. An optional free-running counter can occupy the top register.

## Interface
- ID_W, 4, AXI ID width.
- ADDR_W, 32, byte-address width.
- DATA_W, 32, register width; multiple of 8.
- NUM_REGS, 8, register count; power of two, at least 2.
- clk  in  1  clock, all logic on posedge.
- areset  in  1  reset, asynchronous, active-low.
- awid_i  in  ID_W, awaddr_i  in  ADDR_W, awvalid_i  in  1, awready_o  out  1: write address channel.
- wdata_i  in  DATA_W, wstrb_i  in  DATA_W/8, wvalid_i  in  1, wready_o  out  1: write data channel.
- bid_o  out  ID_W, bresp_o  out  2, bvalid_o  out  1, bready_i  in  1: write response channel.
- arid_i  in  ID_W, araddr_i  in  ADDR_W, arvalid_i  in  1, arready_o  out  1: read address channel.
- rid_o  out  ID_W, rdata_o  out  DATA_W, rresp_o  out  2, rvalid_o  out  1, rready_i  in  1: read data channel.
- regs_o  out  NUM_REGS*DATA_W  flat register contents; register k is at [k*DATA_W +: DATA_W].

## Operation
- Address decode: byte offset B = addr. Let WB = DATA_W/8.
  - If B is not a multiple of WB, the response is SLVERR (2'b10).
  - Otherwise, if B >= NUM_REGS*WB, the response is DECERR (2'b11).
  - Otherwise the index is B/WB and the response is OKAY (2'b00).
- Write FSM states: W_ADDR, W_DATA, W_RESP.
  - W_ADDR: awready_o=1. On the AW handshake, capture awid_i and the decode result, then go to W_DATA.
  - W_DATA: wready_o=1. On the W handshake with an OKAY decode, update each byte lane whose wstrb_i bit is 1. Then go to W_RESP.
  - W_RESP: bvalid_o=1, bid_o=captured ID, bresp_o=decode result. On the B handshake, return to W_ADDR.
  - Error writes change no register.
- Read FSM states: R_ADDR, R_DATA.
  - R_ADDR: arready_o=1. On the AR handshake, capture arid_i and the response. rdata_o is loaded with the register value at that edge, or 0 on error. Go to R_DATA.
  - R_DATA: rvalid_o=1. rid_o, rdata_o and rresp_o are held stable until the R handshake, then return to R_ADDR.
- The two FSMs are fully independent and may be busy at the same time.
- Valid outputs never depend combinationally on the matching ready input.
- Reset values:
  - Both FSMs enter their ADDR state, so awready_o=1 and arready_o=1; wready_o=0.
  - bvalid_o, rvalid_o, bid_o, bresp_o, rid_o, rdata_o, rresp_o are all 0.
  - All registers are 0.
- Reset asserted mid-transaction aborts it immediately. No partial write remains and no response is issued after reset releases.

## Timing
- AW handshake at edge N: wready_o=1 from N+1. The earliest W handshake is at edge N+1.
- W handshake at edge M: the register is updated and bvalid_o=1 at M+1. The earliest AW acceptance for the next write is M+2, since the B handshake at M+1 returns the FSM to W_ADDR.
- AR handshake at edge N: rvalid_o and rdata_o are valid at N+1. Throughput is one read per 2 cycles when rready_i is held at 1.
- Same-register collision: if a W handshake and an AR handshake occur at the same edge on the same index, the read returns the pre-write value.
- A W beat presented before its AW is not accepted. wready_o is 0 outside W_DATA.
- Backpressure: bvalid_o and rvalid_o stay at 1, with their payloads frozen, for as long as the matching ready input is 0.

## Configuration
- S_AXI_REG_BANK_CNT_EN defined:
  - Register NUM_REGS-1 is a read-only counter. It increments by 1 every clk cycle out of reset and wraps from 2^DATA_W-1 to 0.
  - A write to that register returns SLVERR and does not modify the counter.
  - A read returns the counter value sampled at the AR handshake edge.
- Not defined: register NUM_REGS-1 is an ordinary read/write register.

## Structure
- Package s_axi_reg_pkg holds:
  - the response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - the enums w_state_t {W_ADDR, W_DATA, W_RESP} and r_state_t {R_ADDR, R_DATA};
  - the decode function returning {index, resp}.
- Sub-module s_axi_reg_rd_ch contains the read FSM and R payload registers. It receives the register array as an input. The top level holds the write FSM, the register array and the counter.

## Test plan
- Reset, then write 0xABCDEF01 to addr 0x4 with wstrb 0xF and ID 3 -> bid_o=3, bresp_o=OKAY; a read of 0x4 returns 0xABCDEF01 with OKAY.
- Write 0x11223344 to addr 0x8 with wstrb 0x5 over an existing 0xFFFFFFFF -> the register reads 0xFF22FF44.
- Write to addr 0x20 (NUM_REGS=8) -> DECERR; write to addr 0x2 -> SLVERR. Reads of both return 0 with the same responses, and regs_o is unchanged.
- Hold bready_i=0 for 10 cycles after a write -> bvalid_o held at 1 with a stable payload, awready_o=0 throughout; release -> the next AW is accepted 1 cycle later.
- Concurrent write 0x5 and read at index 2 (old value 0x9) at the same edge -> the read returns 0x9, and a subsequent read returns 0x5.
- With S_AXI_REG_BANK_CNT_EN: two reads of addr 0x1C 5 cycles apart differ by 5; a write to 0x1C returns SLVERR. Assert areset mid-W_DATA -> all valids 0, the counter reads near 0 after release.
